// File: rtl/cache_line_fill_controller.sv
// Cache line fill controller: the miss-side master of the cache.
// For each accepted miss it asks the replacement policy for a victim,
// invalidates the victim, writes it back if it is valid and dirty,
// refills the line word by word from memory and commits the new tag.
module cache_line_fill_controller #(
  parameter int SETS           = 4,
  parameter int WAYS           = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int SET_BITS = $clog2(SETS),
  localparam int WAY_BITS = $clog2(WAYS),
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE),
  localparam int TAG_BITS = ADDR_BITS - SET_BITS - OFF_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  // miss request from the lookup stage
  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  logic [ADDR_BITS-1:0] miss_addr,
  // replacement policy
  output logic                 evict_req,
  output logic [SET_BITS-1:0]  evict_set,
  input  logic [WAY_BITS-1:0]  victim_way,
  // metadata array read port
  output logic [SET_BITS-1:0]  meta_rd_set,
  output logic [WAY_BITS-1:0]  meta_rd_way,
  input  logic                 meta_valid,
  input  logic                 meta_dirty,
  input  logic [TAG_BITS-1:0]  meta_tag,
  // metadata array write port
  output logic                 meta_wr_en,
  output logic [SET_BITS-1:0]  meta_wr_set,
  output logic [WAY_BITS-1:0]  meta_wr_way,
  output logic [TAG_BITS-1:0]  meta_wr_tag,
  output logic                 meta_wr_valid,
  output logic                 meta_wr_dirty,
  // data array read port
  output logic [SET_BITS-1:0]  arr_rd_set,
  output logic [WAY_BITS-1:0]  arr_rd_way,
  output logic [OFF_BITS-1:0]  arr_rd_word,
  input  logic [DATA_BITS-1:0] arr_rd_data,
  // data array write port
  output logic                 arr_wr_en,
  output logic [SET_BITS-1:0]  arr_wr_set,
  output logic [WAY_BITS-1:0]  arr_wr_way,
  output logic [OFF_BITS-1:0]  arr_wr_word,
  output logic [DATA_BITS-1:0] arr_wr_data,
  // memory writeback channel
  output logic                 mem_write_valid,
  input  logic                 mem_write_ready,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  // memory fetch channel
  output logic                 mem_read_valid,
  input  logic                 mem_read_ready,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic [DATA_BITS-1:0] mem_read_data,
  // completion
  output logic                 fill_done,
  output logic [WAY_BITS-1:0]  fill_way
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_VICTIM    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FETCH     = 3'd3,
    S_COMMIT    = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [OFF_BITS-1:0] LAST_WORD = OFF_BITS'(WORDS_PER_LINE - 1);

  state_t              state_q, state_d;
  logic [OFF_BITS-1:0] cnt_q, cnt_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] way_q, way_d;
  logic [TAG_BITS-1:0] wb_tag_q, wb_tag_d;
  logic                miss_ready_q, miss_ready_d;

  // The word offset of a miss is irrelevant: the whole line is refilled.
  logic miss_off_unused_s;
  assign miss_off_unused_s = ^miss_addr[OFF_BITS-1:0];

  // miss_ready is a flop so that it stays low while reset is held and rises
  // on the first edge after release; it tracks "next state is IDLE".
  assign miss_ready = miss_ready_q;

  // State, line counter and per-miss context registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      set_q        <= '0;
      way_q        <= '0;
      wb_tag_q     <= '0;
      miss_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      way_q        <= way_d;
      wb_tag_q     <= wb_tag_d;
      miss_ready_q <= miss_ready_d;
    end
  end

  // Next-state logic and all array/memory/policy strobes for the current state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    set_d    = set_q;
    way_d    = way_q;
    wb_tag_d = wb_tag_q;

    evict_req         = 1'b0;
    evict_set         = '0;
    meta_rd_set       = '0;
    meta_rd_way       = '0;
    meta_wr_en        = 1'b0;
    meta_wr_set       = '0;
    meta_wr_way       = '0;
    meta_wr_tag       = '0;
    meta_wr_valid     = 1'b0;
    meta_wr_dirty     = 1'b0;
    arr_rd_set        = '0;
    arr_rd_way        = '0;
    arr_rd_word       = '0;
    arr_wr_en         = 1'b0;
    arr_wr_set        = '0;
    arr_wr_way        = '0;
    arr_wr_word       = '0;
    arr_wr_data       = '0;
    mem_write_valid   = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_read_valid    = 1'b0;
    mem_read_address  = '0;
    fill_done         = 1'b0;
    fill_way          = '0;

    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          tag_d   = miss_addr[ADDR_BITS-1 -: TAG_BITS];
          set_d   = miss_addr[OFF_BITS +: SET_BITS];
          state_d = S_VICTIM;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_VICTIM: begin
        evict_req   = 1'b1;
        evict_set   = set_q;
        way_d       = victim_way;
        meta_rd_set = set_q;
        meta_rd_way = victim_way;
        // Invalidate the victim up front so an abandoned fill never hits.
        meta_wr_en    = 1'b1;
        meta_wr_set   = set_q;
        meta_wr_way   = victim_way;
        meta_wr_tag   = meta_tag;
        meta_wr_valid = 1'b0;
        meta_wr_dirty = 1'b0;
        cnt_d         = '0;
        if (meta_valid && meta_dirty) begin
          wb_tag_d = meta_tag;
          state_d  = S_WRITEBACK;
        end else begin
          state_d  = S_FETCH;
        end
      end

      S_WRITEBACK: begin
        arr_rd_set        = set_q;
        arr_rd_way        = way_q;
        arr_rd_word       = cnt_q;
        mem_write_valid   = 1'b1;
        mem_write_address = {wb_tag_q, set_q, cnt_q};
        mem_write_data    = arr_rd_data;
        if (mem_write_ready) begin
          cnt_d = cnt_q + OFF_BITS'(1);
          if (cnt_q == LAST_WORD) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_FETCH: begin
        mem_read_valid   = 1'b1;
        mem_read_address = {tag_q, set_q, cnt_q};
        if (mem_read_ready) begin
          arr_wr_en   = 1'b1;
          arr_wr_set  = set_q;
          arr_wr_way  = way_q;
          arr_wr_word = cnt_q;
          arr_wr_data = mem_read_data;
          cnt_d       = cnt_q + OFF_BITS'(1);
          if (cnt_q == LAST_WORD) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_COMMIT: begin
        meta_wr_en    = 1'b1;
        meta_wr_set   = set_q;
        meta_wr_way   = way_q;
        meta_wr_tag   = tag_q;
        meta_wr_valid = 1'b1;
        meta_wr_dirty = 1'b0;
        state_d       = S_DONE;
      end

      S_DONE: begin
        fill_done = 1'b1;
        fill_way  = way_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    miss_ready_d = (state_d == S_IDLE);
  end

endmodule

// File: tb/tb_cache_line_fill_controller.sv
// Directed self-checking bench for cache_line_fill_controller (default params).
module tb_cache_line_fill_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic        miss_ready;
  logic [7:0]  miss_addr;
  logic        evict_req;
  logic [1:0]  evict_set;
  logic [1:0]  victim_way;
  logic [1:0]  meta_rd_set, meta_rd_way;
  logic        meta_valid, meta_dirty;
  logic [3:0]  meta_tag;
  logic        meta_wr_en;
  logic [1:0]  meta_wr_set, meta_wr_way;
  logic [3:0]  meta_wr_tag;
  logic        meta_wr_valid, meta_wr_dirty;
  logic [1:0]  arr_rd_set, arr_rd_way, arr_rd_word;
  logic [15:0] arr_rd_data;
  logic        arr_wr_en;
  logic [1:0]  arr_wr_set, arr_wr_way, arr_wr_word;
  logic [15:0] arr_wr_data;
  logic        mem_write_valid, mem_write_ready;
  logic [7:0]  mem_write_address;
  logic [15:0] mem_write_data;
  logic        mem_read_valid, mem_read_ready;
  logic [7:0]  mem_read_address;
  logic [15:0] mem_read_data;
  logic        fill_done;
  logic [1:0]  fill_way;

  int checks = 0;
  int errors = 0;
  int rd_mode = 0;
  int rd_ph = 0;

  always #5 clk = ~clk;

  cache_line_fill_controller dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .evict_req(evict_req), .evict_set(evict_set), .victim_way(victim_way),
    .meta_rd_set(meta_rd_set), .meta_rd_way(meta_rd_way),
    .meta_valid(meta_valid), .meta_dirty(meta_dirty), .meta_tag(meta_tag),
    .meta_wr_en(meta_wr_en), .meta_wr_set(meta_wr_set), .meta_wr_way(meta_wr_way),
    .meta_wr_tag(meta_wr_tag), .meta_wr_valid(meta_wr_valid), .meta_wr_dirty(meta_wr_dirty),
    .arr_rd_set(arr_rd_set), .arr_rd_way(arr_rd_way), .arr_rd_word(arr_rd_word),
    .arr_rd_data(arr_rd_data),
    .arr_wr_en(arr_wr_en), .arr_wr_set(arr_wr_set), .arr_wr_way(arr_wr_way),
    .arr_wr_word(arr_wr_word), .arr_wr_data(arr_wr_data),
    .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_valid(mem_read_valid), .mem_read_ready(mem_read_ready),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .fill_done(fill_done), .fill_way(fill_way)
  );

  // Memory and data-array models: data is a fixed function of the address.
  assign mem_read_data = {mem_read_address ^ 8'h3C, mem_read_address};
  assign arr_rd_data   = {4'hD, arr_rd_set, arr_rd_way, arr_rd_word, 6'h15};

  // Fetch-side ready: always high, or high one cycle in three.
  always @(negedge clk) begin
    if (rd_mode == 0) begin
      mem_read_ready = 1'b1;
    end else begin
      rd_ph = (rd_ph == 2) ? 0 : rd_ph + 1;
      mem_read_ready = (rd_ph == 0);
    end
  end

  // Event log, sampled at the active edge (pre-update values).
  int cyc = 0;
  int ev_n = 0, rd_n = 0, wr_n = 0, arr_n = 0, mw_n = 0, done_n = 0, acc_n = 0;
  int hold_err = 0, spur_wr = 0;
  logic [1:0]  ev_set [64];
  logic [7:0]  rd_addr [64];
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  logic [1:0]  aw_way [64], aw_word [64], aw_set [64];
  logic [15:0] aw_data [64];
  logic        mw_valid [64], mw_dirty [64];
  logic [3:0]  mw_tag [64];
  logic [1:0]  mw_way [64], mw_set [64];
  int          done_cyc [64], acc_cyc [64];
  logic [1:0]  done_way [64];
  logic        prev_rv = 1'b0, prev_hs = 1'b0;
  logic [7:0]  prev_ra = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (evict_req) begin ev_set[ev_n] <= evict_set; ev_n <= ev_n + 1; end
    if (mem_read_valid && mem_read_ready) begin rd_addr[rd_n] <= mem_read_address; rd_n <= rd_n + 1; end
    if (mem_write_valid && mem_write_ready) begin
      wr_addr[wr_n] <= mem_write_address; wr_data[wr_n] <= mem_write_data; wr_n <= wr_n + 1;
    end
    if (arr_wr_en) begin
      aw_way[arr_n] <= arr_wr_way; aw_word[arr_n] <= arr_wr_word;
      aw_set[arr_n] <= arr_wr_set; aw_data[arr_n] <= arr_wr_data; arr_n <= arr_n + 1;
    end
    if (arr_wr_en && !(mem_read_valid && mem_read_ready)) spur_wr <= spur_wr + 1;
    if (meta_wr_en) begin
      mw_valid[mw_n] <= meta_wr_valid; mw_dirty[mw_n] <= meta_wr_dirty; mw_tag[mw_n] <= meta_wr_tag;
      mw_way[mw_n] <= meta_wr_way; mw_set[mw_n] <= meta_wr_set; mw_n <= mw_n + 1;
    end
    if (fill_done) begin done_cyc[done_n] <= cyc; done_way[done_n] <= fill_way; done_n <= done_n + 1; end
    if (miss_valid && miss_ready) begin acc_cyc[acc_n] <= cyc; acc_n <= acc_n + 1; end
    if (mem_read_valid && prev_rv && !prev_hs && mem_read_address != prev_ra) hold_err <= hold_err + 1;
    prev_rv <= mem_read_valid;
    prev_hs <= mem_read_valid && mem_read_ready;
    prev_ra <= mem_read_address;
  end

  task automatic issue_miss(input logic [7:0] a);
    int base;
    int i;
    base = acc_n;
    i = 0;
    miss_addr  = a;
    miss_valid = 1'b1;
    @(negedge clk);
    while (acc_n == base && i < 10) begin @(negedge clk); i++; end
    miss_valid = 1'b0;
    checks++;
    if (acc_n !== base + 1) begin
      errors++; $display("FAIL miss_accept: accepts %0d, required %0d", acc_n - base, 1);
    end
  endtask

  task automatic wait_done(input int base, input string name);
    int i;
    i = 0;
    while (done_n == base && i < 60) begin @(negedge clk); i++; end
    checks++;
    if (done_n == base) begin
      errors++; $display("FAIL %s_timeout: fill_done count %0d, required %0d", name, done_n - base, 1);
    end
  endtask

  // Checks one complete fill against its expected transactions.
  task automatic check_fill(input string name, input int eb, input int rb, input int wb, input int ab,
                            input int mb, input int db, input int cb, input logic [7:0] rd0,
                            input int nwr, input logic [7:0] wr0, input logic [1:0] set,
                            input logic [1:0] way, input logic [3:0] old_tag, input logic [3:0] new_tag,
                            input int lat);
    logic [7:0]  ea;
    logic [15:0] ed;
    checks++;
    if (ev_n - eb !== 1 || ev_set[eb] !== set) begin
      errors++; $display("FAIL %s_evict: pulses %0d set %0d, required 1 set %0d", name, ev_n - eb, ev_set[eb], set);
    end
    checks++;
    if (rd_n - rb !== 4) begin errors++; $display("FAIL %s_reads: %0d, required 4", name, rd_n - rb); end
    for (int i = 0; i < 4; i++) begin
      ea = rd0 + 8'(i);
      ed = {ea ^ 8'h3C, ea};
      checks++;
      if (rd_addr[rb+i] !== ea) begin
        errors++; $display("FAIL %s_rd_addr%0d: %h, required %h", name, i, rd_addr[rb+i], ea);
      end
      checks++;
      if (aw_way[ab+i] !== way || aw_set[ab+i] !== set || aw_word[ab+i] !== 2'(i) || aw_data[ab+i] !== ed) begin
        errors++; $display("FAIL %s_arr_wr%0d: set %0d way %0d word %0d data %h, required %0d %0d %0d %h",
                           name, i, aw_set[ab+i], aw_way[ab+i], aw_word[ab+i], aw_data[ab+i], set, way, i, ed);
      end
    end
    checks++;
    if (arr_n - ab !== 4) begin errors++; $display("FAIL %s_arr_count: %0d, required 4", name, arr_n - ab); end
    checks++;
    if (wr_n - wb !== nwr) begin errors++; $display("FAIL %s_writes: %0d, required %0d", name, wr_n - wb, nwr); end
    for (int i = 0; i < nwr; i++) begin
      ea = wr0 + 8'(i);
      ed = {4'hD, set, way, 2'(i), 6'h15};
      checks++;
      if (wr_addr[wb+i] !== ea || wr_data[wb+i] !== ed) begin
        errors++; $display("FAIL %s_wb%0d: addr %h data %h, required %h %h", name, i, wr_addr[wb+i], wr_data[wb+i], ea, ed);
      end
    end
    checks++;
    if (mw_n - mb !== 2 || mw_valid[mb] !== 1'b0 || mw_dirty[mb] !== 1'b0 || mw_tag[mb] !== old_tag
        || mw_way[mb] !== way || mw_set[mb] !== set) begin
      errors++; $display("FAIL %s_invalidate: n %0d v %b d %b tag %h way %0d set %0d, required 2 0 0 %h %0d %0d",
                         name, mw_n - mb, mw_valid[mb], mw_dirty[mb], mw_tag[mb], mw_way[mb], mw_set[mb], old_tag, way, set);
    end
    checks++;
    if (mw_valid[mb+1] !== 1'b1 || mw_dirty[mb+1] !== 1'b0 || mw_tag[mb+1] !== new_tag
        || mw_way[mb+1] !== way || mw_set[mb+1] !== set) begin
      errors++; $display("FAIL %s_commit: v %b d %b tag %h way %0d set %0d, required 1 0 %h %0d %0d",
                         name, mw_valid[mb+1], mw_dirty[mb+1], mw_tag[mb+1], mw_way[mb+1], mw_set[mb+1], new_tag, way, set);
    end
    // The log stamps fill_done one edge after the edge that raised it.
    checks++;
    if (lat >= 0 && done_cyc[db] - acc_cyc[cb] - 1 !== lat) begin
      errors++; $display("FAIL %s_latency: %0d, required %0d", name, done_cyc[db] - acc_cyc[cb] - 1, lat);
    end
    checks++;
    if (done_way[db] !== way) begin errors++; $display("FAIL %s_fill_way: %0d, required %0d", name, done_way[db], way); end
  endtask

  task automatic test_reset();
    reset = 1'b0; miss_valid = 1'b0; miss_addr = 8'hFF; victim_way = 2'd0;
    meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = 4'h0; mem_write_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({miss_ready, evict_req, meta_wr_en, arr_wr_en, mem_write_valid, mem_read_valid, fill_done} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: %b, required 0000000",
                         {miss_ready, evict_req, meta_wr_en, arr_wr_en, mem_write_valid, mem_read_valid, fill_done});
    end
    checks++;
    if (mem_read_address !== 8'h00 || mem_write_address !== 8'h00 || arr_wr_data !== 16'h0000) begin
      errors++; $display("FAIL reset_addr: rd %h wr %h data %h, required 0", mem_read_address, mem_write_address, arr_wr_data);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", miss_ready); end
    // Both readies are high while idle: nothing may move.
    repeat (3) @(negedge clk);
    checks++;
    if (rd_n !== 0 || wr_n !== 0 || arr_n !== 0 || spur_wr !== 0) begin
      errors++; $display("FAIL idle_ready_ignored: rd %0d wr %0d arr %0d, required 0", rd_n, wr_n, arr_n);
    end
  endtask

  task automatic test_clean();
    int eb, rb, wb, ab, mb, db, cb;
    eb = ev_n; rb = rd_n; wb = wr_n; ab = arr_n; mb = mw_n; db = done_n; cb = acc_n;
    rd_mode = 0; meta_valid = 1'b0; meta_dirty = 1'b1; meta_tag = 4'h5; victim_way = 2'd2;
    issue_miss(8'hB6);
    wait_done(db, "clean");
    check_fill("clean", eb, rb, wb, ab, mb, db, cb, 8'hB4, 0, 8'h00, 2'd1, 2'd2, 4'h5, 4'hB, 6);
  endtask

  task automatic test_dirty();
    int eb, rb, wb, ab, mb, db, cb;
    eb = ev_n; rb = rd_n; wb = wr_n; ab = arr_n; mb = mw_n; db = done_n; cb = acc_n;
    rd_mode = 0; meta_valid = 1'b1; meta_dirty = 1'b1; meta_tag = 4'h3; victim_way = 2'd1;
    issue_miss(8'hB6);
    wait_done(db, "dirty");
    check_fill("dirty", eb, rb, wb, ab, mb, db, cb, 8'hB4, 4, 8'h34, 2'd1, 2'd1, 4'h3, 4'hB, 10);
  endtask

  task automatic test_valid_clean();
    int eb, rb, wb, ab, mb, db, cb;
    eb = ev_n; rb = rd_n; wb = wr_n; ab = arr_n; mb = mw_n; db = done_n; cb = acc_n;
    rd_mode = 0; meta_valid = 1'b1; meta_dirty = 1'b0; meta_tag = 4'h7; victim_way = 2'd3;
    issue_miss(8'h2D);
    wait_done(db, "vclean");
    check_fill("vclean", eb, rb, wb, ab, mb, db, cb, 8'h2C, 0, 8'h00, 2'd3, 2'd3, 4'h7, 4'h2, 6);
  endtask

  task automatic test_backpressure();
    int eb, rb, wb, ab, mb, db, cb, hb;
    eb = ev_n; rb = rd_n; wb = wr_n; ab = arr_n; mb = mw_n; db = done_n; cb = acc_n; hb = hold_err;
    rd_mode = 1; meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = 4'h9; victim_way = 2'd0;
    issue_miss(8'h48);
    wait_done(db, "bp");
    rd_mode = 0;
    check_fill("bp", eb, rb, wb, ab, mb, db, cb, 8'h48, 0, 8'h00, 2'd2, 2'd0, 4'h9, 4'h4, -1);
    checks++;
    if (hold_err !== hb || spur_wr !== 0) begin
      errors++; $display("FAIL bp_addr_hold: moves %0d spurious %0d, required 0 0", hold_err - hb, spur_wr);
    end
    // With ready one cycle in three the fill takes longer than 6 cycles.
    checks++;
    if (done_cyc[db] - acc_cyc[cb] - 1 <= 6) begin
      errors++; $display("FAIL bp_latency: %0d, required more than 6", done_cyc[db] - acc_cyc[cb] - 1);
    end
  endtask

  task automatic test_back_to_back();
    int eb, cb, db, i;
    eb = ev_n; cb = acc_n; db = done_n; i = 0;
    rd_mode = 0; meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = 4'h1; victim_way = 2'd2;
    miss_addr = 8'hB6; miss_valid = 1'b1;
    while (acc_n == cb && i < 10) begin @(negedge clk); i++; end
    wait_done(db, "b2b_first");
    checks++;
    if (acc_n !== cb + 1) begin errors++; $display("FAIL b2b_busy_accept: %0d, required 1", acc_n - cb); end
    i = 0;
    while (acc_n == cb + 1 && i < 10) begin @(negedge clk); i++; end
    checks++;
    if (acc_cyc[cb+1] !== done_cyc[db] + 1) begin
      errors++; $display("FAIL b2b_second_accept: cycle %0d, required %0d", acc_cyc[cb+1], done_cyc[db] + 1);
    end
    wait_done(db + 1, "b2b_second");
    miss_valid = 1'b0;
    checks++;
    if (ev_n - eb !== 2 || acc_n - cb !== 2) begin
      errors++; $display("FAIL b2b_evicts: evicts %0d accepts %0d, required 2 2", ev_n - eb, acc_n - cb);
    end
  endtask

  task automatic test_reset_mid();
    int ab, mb, db, i;
    ab = arr_n; db = done_n; i = 0;
    rd_mode = 0; meta_valid = 1'b0; meta_dirty = 1'b0; meta_tag = 4'hE; victim_way = 2'd1;
    miss_addr = 8'h6A; miss_valid = 1'b1;
    while (arr_n < ab + 2 && i < 20) begin @(negedge clk); i++; miss_valid = 1'b0; end
    reset = 1'b0;
    #1;
    mb = mw_n;
    checks++;
    if ({miss_ready, evict_req, meta_wr_en, arr_wr_en, mem_write_valid, mem_read_valid, fill_done} !== 7'b0
        || mem_read_address !== 8'h00) begin
      errors++; $display("FAIL mid_reset_outputs: %b addr %h, required 0000000 00",
                         {miss_ready, evict_req, meta_wr_en, arr_wr_en, mem_write_valid, mem_read_valid, fill_done},
                         mem_read_address);
    end
    checks++;
    if (mw_valid[mw_n-1] !== 1'b0 || mw_way[mw_n-1] !== 2'd1 || mw_set[mw_n-1] !== 2'd2) begin
      errors++; $display("FAIL mid_reset_last_meta: v %b way %0d set %0d, required 0 1 2",
                         mw_valid[mw_n-1], mw_way[mw_n-1], mw_set[mw_n-1]);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: %b, required 1", miss_ready); end
    repeat (3) @(negedge clk);
    checks++;
    if (mw_n !== mb || done_n !== db || arr_n !== ab + 2) begin
      errors++; $display("FAIL mid_reset_abandon: meta %0d done %0d arr %0d, required 0 0 2",
                         mw_n - mb, done_n - db, arr_n - ab);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_dirty();
    test_valid_clean();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_clean();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cache_line_fill_controller.md
Name: cache_line_fill_controller

Overview:
- Miss-side master for the cache replacement policy.
- Accepts one miss at a time and fetches the victim way from the per-set replacement policy, pulsing evict_req once per miss.
- Writes back the victim line to memory if it is valid and dirty, then refills it word by word from memory and commits the new tag.
- Sits between the cache lookup stage, the tag/data arrays and the memory interface.

Parameters:
SETS, 4, number of sets (power of 2)
WAYS, 4, ways per set (power of 2)
ADDR_BITS, 8, word address width
DATA_BITS, 16, data word width
WORDS_PER_LINE, 4, words per line (power of 2, ≥2)
Derived (localparam): SET_BITS=$clog2(SETS), WAY_BITS=$clog2(WAYS), OFF_BITS=$clog2(WORDS_PER_LINE), TAG_BITS=ADDR_BITS-SET_BITS-OFF_BITS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
miss_valid  in  1  miss request
miss_ready  out  1  high only in IDLE
miss_addr  in  ADDR_BITS  missing word address {tag,set,offset}
evict_req  out  1  one-cycle pulse to replacement policy
evict_set  out  SET_BITS  set presented to policy
victim_way  in  WAY_BITS  combinational victim from policy
meta_rd_set / meta_rd_way  out  SET_BITS / WAY_BITS  metadata read address
meta_valid, meta_dirty  in  1 each  combinational metadata read data
meta_tag  in  TAG_BITS  combinational metadata read tag
meta_wr_en  out  1  metadata write strobe
meta_wr_set / meta_wr_way / meta_wr_tag  out  SET/WAY/TAG_BITS  metadata write address and tag
meta_wr_valid, meta_wr_dirty  out  1 each  metadata write bits
arr_rd_set / arr_rd_way / arr_rd_word  out  SET/WAY/OFF_BITS  data array read address
arr_rd_data  in  DATA_BITS  combinational data read
arr_wr_en  out  1  data array write strobe
arr_wr_set / arr_wr_way / arr_wr_word / arr_wr_data  out  SET/WAY/OFF/DATA_BITS  data array write port
mem_write_valid / mem_write_ready  out / in  1  writeback handshake
mem_write_address / mem_write_data  out  ADDR_BITS / DATA_BITS  writeback word
mem_read_valid / mem_read_ready  out / in  1  fetch handshake
mem_read_address / mem_read_data  out / in  ADDR_BITS / DATA_BITS  fetch word
fill_done  out  1  one-cycle completion pulse
fill_way  out  WAY_BITS  way filled, valid with fill_done

Behaviour:
- Reset (reset=0, async): state=IDLE; word counter and all registers 0; every strobe/valid output 0; address/data outputs 0. miss_ready=1 from the first cycle after release.
- State machine: IDLE -> VICTIM -> (WRITEBACK) -> FETCH -> COMMIT -> DONE -> IDLE.
- IDLE:
  - miss_ready=1.
  - On miss_valid: latch tag/set from miss_addr (offset ignored); go to VICTIM.
- VICTIM (exactly 1 cycle):
  - evict_req=1 with evict_set=latched set. This is the only cycle evict_req is high per miss.
  - Latch victim_way.
  - meta_rd_* = {set, victim_way}.
  - Same cycle: meta_wr_en=1 with valid=0, dirty=0 and the old tag, invalidating the victim before any overwrite.
  - If meta_valid && meta_dirty: latch meta_tag as wb_tag and go to WRITEBACK. Otherwise go to FETCH.
  - Counter cleared to 0.
- WRITEBACK:
  - arr_rd_* = {set, way, cnt}.
  - mem_write_valid=1, mem_write_address={wb_tag,set,cnt}, mem_write_data=arr_rd_data.
  - Each cycle with mem_write_ready=1 accepts one word and cnt++.
  - Acceptance at cnt=WORDS_PER_LINE-1 wraps cnt to 0 and moves to FETCH.
  - mem_write_ready may assert in the same cycle valid first rises.
- FETCH:
  - mem_read_valid=1, mem_read_address={tag,set,cnt}.
  - Each cycle with mem_read_ready=1: arr_wr_en=1, arr_wr_*={set,way,cnt,mem_read_data} (combinational from the handshake), cnt++.
  - The last word moves to COMMIT.
- COMMIT (1 cycle): meta_wr_en=1, {set,way}, tag=latched tag, valid=1, dirty=0.
- DONE (1 cycle): fill_done=1, fill_way=way; then IDLE. The next miss may be accepted in the following cycle.
- Latency with zero-wait memory, counting from the miss-accept edge:
  - Clean victim: fill_done 2+WORDS_PER_LINE cycles later (6 at defaults).
  - Dirty victim: add WORDS_PER_LINE cycles (10 at defaults).
- Boundary conditions:
  - miss_valid outside IDLE is ignored.
  - A ready input while the matching valid is low is ignored.
  - mem_*_ready held continuously streams one word per cycle.
  - A reset mid-operation abandons the fill: the victim is already invalid, so a partially written line is never hit. No metadata write occurs after reset.
  - Address concatenation is exact width; no arithmetic overflow is possible (cnt wraps modulo WORDS_PER_LINE).

Test Plan:
- Clean victim: meta_valid=0, victim_way=2, miss_addr=0xB6, zero-wait memory -> evict_req exactly 1 cycle with evict_set=1; reads at 0xB4,0xB5,0xB6,0xB7; arr_wr way 2 words 0–3; COMMIT tag=0xB valid=1 dirty=0; fill_done with fill_way=2 at 6 cycles.
- Dirty victim: meta_valid=1, meta_dirty=1, meta_tag=0x3, victim_way=1, miss_addr=0xB6 -> writes to 0x34–0x37 with array data of set1/way1, then reads 0xB4–0xB7; fill_done at 10 cycles.
- Back-pressure: mem_read_ready asserted only every third cycle -> address holds steady between handshakes, exactly 4 arr_wr_en pulses, fill completes.
- Miss during busy: miss_valid held high throughout -> miss_ready=0 until DONE; second miss is accepted the cycle after fill_done, with a second evict_req pulse.
- Reset mid-FETCH after 2 words -> all outputs 0 immediately; the victim's last metadata write was valid=0; no COMMIT; miss_ready=1 after release.
- Valid-clean victim (meta_valid=1, meta_dirty=0) -> no mem_write_valid; goes directly to FETCH.
